// File: rtl/algo_1r1w1p_wrbuf_top.sv
// Single-port SRAM wrapper presenting one read and one write port per cycle.
// Writes that collide with a read are parked in a small FIFO write buffer and
// drained into the macro during cycles with no read. Pending entries are
// forwarded to reads so every read sees the latest accepted write.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   write/wr_adr/din    write request
//   read/rd_adr         read request
//   ready               initialisation done, requests accepted
//   rd_vld/rd_dout      read return, fixed latency SRAM_DELAY+FLOPOUT
//   wr_full/wr_cnt      write buffer full flag and occupancy
//   ovf_err             sticky: a write was dropped on buffer overflow
//   t1_*                single-port macro interface
module algo_1r1w1p_wrbuf_top #(
    parameter int WIDTH      = 64,
    parameter int NUMADDR    = 8192,
    parameter int BITADDR    = 13,
    parameter int NUMWBUF    = 4,
    parameter int BITWBUF    = 2,
    parameter int SRAM_DELAY = 1,
    parameter int FLOPOUT    = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               write,
    input  logic [BITADDR-1:0] wr_adr,
    input  logic [WIDTH-1:0]   din,
    input  logic               read,
    input  logic [BITADDR-1:0] rd_adr,
    output logic               ready,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dout,
    output logic               wr_full,
    output logic [BITWBUF:0]   wr_cnt,
    output logic               ovf_err,
    output logic               t1_readA,
    output logic               t1_writeA,
    output logic [BITADDR-1:0] t1_addrA,
    output logic [WIDTH-1:0]   t1_dinA,
    output logic [WIDTH-1:0]   t1_bwA,
    input  logic [WIDTH-1:0]   t1_doutA
);

    localparam int                 CW      = BITWBUF + 1;
    localparam logic [BITWBUF:0]   FullCnt = CW'(NUMWBUF);
    localparam logic [BITWBUF-1:0] LastPtr = BITWBUF'(NUMWBUF - 1);
    localparam logic [BITADDR-1:0] LastAdr = BITADDR'(NUMADDR - 1);

    typedef enum logic {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [BITADDR-1:0] init_q, init_d;

    logic [BITADDR-1:0] buf_adr_q [NUMWBUF];
    logic [BITADDR-1:0] buf_adr_d [NUMWBUF];
    logic [WIDTH-1:0]   buf_dat_q [NUMWBUF];
    logic [WIDTH-1:0]   buf_dat_d [NUMWBUF];
    logic [NUMWBUF-1:0] buf_vld_q, buf_vld_d;
    logic [BITWBUF-1:0] head_q, head_d, tail_q, tail_d;
    logic [BITWBUF:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic               drain, store, enq;
    logic               wr_hit, rd_hit, buf_empty, head_match;
    logic [BITWBUF-1:0] wr_hit_idx;
    logic [WIDTH-1:0]   rd_hit_dat;

    function automatic logic [BITWBUF-1:0] ptr_inc(input logic [BITWBUF-1:0] p);
        return (p == LastPtr) ? '0 : p + BITWBUF'(1);
    endfunction

    // Associative lookup; addresses are unique so at most one slot matches.
    always_comb begin
        wr_hit     = 1'b0;
        wr_hit_idx = '0;
        rd_hit     = 1'b0;
        rd_hit_dat = '0;
        for (int i = 0; i < NUMWBUF; i++) begin
            if (buf_vld_q[i] && buf_adr_q[i] == wr_adr) begin
                wr_hit     = 1'b1;
                wr_hit_idx = BITWBUF'(i);
            end
            if (buf_vld_q[i] && buf_adr_q[i] == rd_adr) begin
                rd_hit     = 1'b1;
                rd_hit_dat = buf_dat_q[i];
            end
        end
    end

    assign buf_empty  = (cnt_q == '0);
    assign head_match = !buf_empty && (buf_adr_q[head_q] == wr_adr);

    always_comb begin
        state_d   = state_q;
        init_d    = init_q;
        buf_adr_d = buf_adr_q;
        buf_dat_d = buf_dat_q;
        buf_vld_d = buf_vld_q;
        head_d    = head_q;
        tail_d    = tail_q;
        ovf_d     = ovf_q;
        t1_readA  = 1'b0;
        t1_writeA = 1'b0;
        t1_addrA  = '0;
        t1_dinA   = '0;
        t1_bwA    = '0;
        drain     = 1'b0;
        store     = 1'b0;
        enq       = 1'b0;

        // Macro strobes are held off while reset is asserted.
        if (!rst) begin
            unique case (state_q)
                StInit: begin
                    t1_writeA = 1'b1;
                    t1_addrA  = init_q;
                    t1_bwA    = '1;
                    if (init_q == LastAdr) begin
                        state_d = StRun;
                    end else begin
                        init_d = init_q + BITADDR'(1);
                    end
                end
                StRun: begin
                    if (read) begin
                        t1_readA = 1'b1;
                        t1_addrA = rd_adr;
                        store    = write;
                    end else if (write) begin
                        t1_writeA = 1'b1;
                        t1_bwA    = '1;
                        if (buf_empty) begin
                            t1_addrA = wr_adr;
                            t1_dinA  = din;
                        end else if (head_match) begin
                            // New data supersedes the head: write it directly.
                            drain    = 1'b1;
                            t1_addrA = wr_adr;
                            t1_dinA  = din;
                        end else begin
                            drain    = 1'b1;
                            store    = 1'b1;
                            t1_addrA = buf_adr_q[head_q];
                            t1_dinA  = buf_dat_q[head_q];
                        end
                    end else if (!buf_empty) begin
                        drain     = 1'b1;
                        t1_writeA = 1'b1;
                        t1_bwA    = '1;
                        t1_addrA  = buf_adr_q[head_q];
                        t1_dinA   = buf_dat_q[head_q];
                    end
                end
                default: state_d = StInit;
            endcase
        end

        // Drain is applied before enqueue: when full, tail == head and the
        // freed head slot is reused in the same cycle.
        if (drain) begin
            buf_vld_d[head_q] = 1'b0;
            head_d            = ptr_inc(head_q);
        end
        if (store) begin
            if (wr_hit) begin
                buf_dat_d[wr_hit_idx] = din;
            end else if (cnt_q != FullCnt || drain) begin
                enq               = 1'b1;
                buf_adr_d[tail_q] = wr_adr;
                buf_dat_d[tail_q] = din;
                buf_vld_d[tail_q] = 1'b1;
                tail_d            = ptr_inc(tail_q);
            end else begin
                ovf_d = 1'b1;
            end
        end
        cnt_d = cnt_q + CW'(enq) - CW'(drain);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StInit;
            init_q    <= '0;
            buf_vld_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < NUMWBUF; i++) begin
                buf_adr_q[i] <= '0;
                buf_dat_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            init_q    <= init_d;
            buf_vld_q <= buf_vld_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            buf_adr_q <= buf_adr_d;
            buf_dat_q <= buf_dat_d;
        end
    end

    // Read return pipeline, aligned with the macro latency. Forwarded data is
    // captured in the request cycle, before that cycle's buffer update.
    logic [SRAM_DELAY-1:0] pv_q, ph_q;
    logic [WIDTH-1:0]      pd_q [SRAM_DELAY];
    logic                  ret_vld;
    logic [WIDTH-1:0]      ret_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            ph_q <= '0;
            for (int i = 0; i < SRAM_DELAY; i++) begin
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= t1_readA;
            ph_q[0] <= rd_hit;
            pd_q[0] <= rd_hit_dat;
            for (int i = 1; i < SRAM_DELAY; i++) begin
                pv_q[i] <= pv_q[i-1];
                ph_q[i] <= ph_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end
    end

    assign ret_vld = pv_q[SRAM_DELAY-1];
    assign ret_dat = ph_q[SRAM_DELAY-1] ? pd_q[SRAM_DELAY-1] : t1_doutA;

    generate
        if (FLOPOUT != 0) begin : g_flop_out
            logic             out_vld_q;
            logic [WIDTH-1:0] out_dat_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld_q <= 1'b0;
                    out_dat_q <= '0;
                end else begin
                    out_vld_q <= ret_vld;
                    out_dat_q <= ret_vld ? ret_dat : '0;
                end
            end
            assign rd_vld  = out_vld_q;
            assign rd_dout = out_dat_q;
        end else begin : g_comb_out
            assign rd_vld  = ret_vld;
            assign rd_dout = ret_vld ? ret_dat : '0;
        end
    endgenerate

    assign ready   = (state_q == StRun);
    assign wr_cnt  = cnt_q;
    assign wr_full = (cnt_q == FullCnt);
    assign ovf_err = ovf_q;

endmodule

// File: tb/tb_algo_1r1w1p_wrbuf_top.sv
// Bench for algo_1r1w1p_wrbuf_top: small depth (16), behavioural single-port
// macro, and a reference model holding the logical memory image plus the
// write buffer as a queue of (address, data) entries.
module tb_algo_1r1w1p_wrbuf_top;

    logic        clk, rst;
    logic        write, read;
    logic [3:0]  wr_adr, rd_adr;
    logic [63:0] din;
    logic        ready, rd_vld, wr_full, ovf_err;
    logic [63:0] rd_dout;
    logic [2:0]  wr_cnt;
    logic        t1_readA, t1_writeA;
    logic [3:0]  t1_addrA;
    logic [63:0] t1_dinA, t1_bwA, t1_doutA;

    int errors = 0;
    int checks = 0;

    algo_1r1w1p_wrbuf_top #(
        .WIDTH(64), .NUMADDR(16), .BITADDR(4), .NUMWBUF(4), .BITWBUF(2),
        .SRAM_DELAY(1), .FLOPOUT(0)
    ) dut (
        .clk(clk), .rst(rst), .write(write), .wr_adr(wr_adr), .din(din),
        .read(read), .rd_adr(rd_adr), .ready(ready), .rd_vld(rd_vld),
        .rd_dout(rd_dout), .wr_full(wr_full), .wr_cnt(wr_cnt), .ovf_err(ovf_err),
        .t1_readA(t1_readA), .t1_writeA(t1_writeA), .t1_addrA(t1_addrA),
        .t1_dinA(t1_dinA), .t1_bwA(t1_bwA), .t1_doutA(t1_doutA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural macro: one-cycle read latency, garbage contents at power-up.
    logic [63:0] mem [16];
    logic        seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            seeded <= 1'b1;
            for (int i = 0; i < 16; i++) mem[i] <= {$urandom, $urandom};
        end else begin
            if (t1_writeA) mem[t1_addrA] <= (mem[t1_addrA] & ~t1_bwA) | (t1_dinA & t1_bwA);
            if (t1_readA) t1_doutA <= mem[t1_addrA];
        end
    end

    // Reference model
    typedef struct packed {
        logic [3:0]  a;
        logic [63:0] d;
    } ent_t;
    ent_t        q[$];
    logic [63:0] lm [16];
    logic        m_ovf;
    logic        exp_vld;
    logic [63:0] exp_dat;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 16; i++) lm[i] = 64'h0;
        m_ovf   = 1'b0;
        exp_vld = 1'b0;
        exp_dat = 64'h0;
    endtask

    function automatic int find_ent(input logic [3:0] a);
        foreach (q[i]) if (q[i].a == a) return i;
        return -1;
    endfunction

    task automatic store(input logic [3:0] wa, input logic [63:0] wd);
        int k;
        ent_t e;
        k = find_ent(wa);
        if (k >= 0) begin
            q[k].d = wd;
            lm[wa] = wd;
        end else if (q.size() < 4) begin
            e.a = wa;
            e.d = wd;
            q.push_back(e);
            lm[wa] = wd;
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_step(input logic r, input logic [3:0] ra, input logic w,
                              input logic [3:0] wa, input logic [63:0] wd);
        ent_t h;
        exp_vld = r;
        exp_dat = lm[ra];
        if (r) begin
            if (w) store(wa, wd);
        end else if (w) begin
            if (q.size() == 0) begin
                lm[wa] = wd;
            end else begin
                h = q.pop_front();
                if (h.a == wa) lm[wa] = wd;
                else store(wa, wd);
            end
        end else if (q.size() > 0) begin
            h = q.pop_front();
        end
    endtask

    // Called at posedge+1; leaves time at posedge+2 with inputs applied.
    task automatic drive(input logic r, input logic [3:0] ra, input logic w,
                         input logic [3:0] wa, input logic [63:0] wd);
        read   = r;
        rd_adr = ra;
        write  = w;
        wr_adr = wa;
        din    = wd;
        #1;
        chk("excl", 64'(t1_readA & t1_writeA), 64'h0);
        model_step(r, ra, w, wa, wd);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("rd_vld", 64'(rd_vld), 64'(exp_vld));
        if (exp_vld) chk("rd_dout", rd_dout, exp_dat);
        chk("wr_cnt", 64'(wr_cnt), 64'(q.size()));
        chk("wr_full", 64'(wr_full), 64'(q.size() == 4));
        chk("ovf_err", 64'(ovf_err), 64'(m_ovf));
        chk("ready", 64'(ready), 64'h1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'h0, 1'b0, 4'h0, 64'h0);
            tick();
        end
    endtask

    task automatic chk_mwr(input string tag, input logic [3:0] a, input logic [63:0] d);
        chk({tag, "_we"}, 64'(t1_writeA), 64'h1);
        chk({tag, "_adr"}, 64'(t1_addrA), 64'(a));
        chk({tag, "_din"}, t1_dinA, d);
    endtask

    // Requests applied during INIT must be ignored.
    task automatic run_init();
        for (int k = 0; k < 16; k++) begin
            read   = 1'($urandom_range(0, 1));
            rd_adr = 4'($urandom_range(0, 15));
            write  = 1'($urandom_range(0, 1));
            wr_adr = 4'($urandom_range(0, 15));
            din    = {$urandom, $urandom};
            #1;
            chk("init_we", 64'(t1_writeA), 64'h1);
            chk("init_adr", 64'(t1_addrA), 64'(k));
            chk("init_din", t1_dinA, 64'h0);
            chk("init_bw", t1_bwA, {64{1'b1}});
            chk("init_rd", 64'(t1_readA), 64'h0);
            chk("init_rdy", 64'(ready), 64'h0);
            chk("init_rvld", 64'(rd_vld), 64'h0);
            chk("init_cnt", 64'(wr_cnt), 64'h0);
            @(posedge clk);
            #1;
        end
        read  = 1'b0;
        write = 1'b0;
        chk("ready_up", 64'(ready), 64'h1);
    endtask

    logic        r_r, r_w;
    logic [3:0]  r_ra, r_wa;
    logic [63:0] r_wd;

    initial begin
        rst = 1'b1;
        read = 1'b0; write = 1'b0; rd_adr = '0; wr_adr = '0; din = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(ready), 64'h0);
        chk("rst_rvld", 64'(rd_vld), 64'h0);
        chk("rst_dout", rd_dout, 64'h0);
        chk("rst_cnt", 64'(wr_cnt), 64'h0);
        chk("rst_full", 64'(wr_full), 64'h0);
        chk("rst_ovf", 64'(ovf_err), 64'h0);
        chk("rst_rda", 64'(t1_readA), 64'h0);
        chk("rst_wra", 64'(t1_writeA), 64'h0);
        rst = 1'b0;
        run_init();

        // Memory zeroed by INIT
        drive(1'b1, 4'd5, 1'b0, 4'd0, 64'h0); tick();

        // Read/write collision parks the write; an idle cycle drains it
        drive(1'b1, 4'd7, 1'b1, 4'd3, 64'hA5); tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 64'h0);
        chk_mwr("drain3", 4'd3, 64'hA5);
        tick();

        // Forwarding from a buffered entry; reads do not drain
        drive(1'b1, 4'd0, 1'b1, 4'd3, 64'hA5); tick();
        drive(1'b1, 4'd3, 1'b0, 4'd0, 64'h0);
        chk("fwd_rda", 64'(t1_readA), 64'h1);
        chk("fwd_adr", 64'(t1_addrA), 64'd3);
        tick();
        idle(1);

        // Same-address read and write returns old contents
        drive(1'b1, 4'd9, 1'b1, 4'd9, 64'h11); tick();
        drive(1'b1, 4'd9, 1'b0, 4'd0, 64'h0); tick();
        idle(1);

        // Overflow: fifth colliding write to a new address is dropped
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(i), 1'b1, 4'(10 + i), 64'hC0 + 64'(i));
            tick();
        end
        idle(5);
        chk("ovf_sticky", 64'(ovf_err), 64'h1);
        drive(1'b1, 4'd14, 1'b0, 4'd0, 64'h0); tick();

        // Merge in place
        drive(1'b1, 4'd0, 1'b1, 4'd4, 64'h1); tick();
        drive(1'b1, 4'd0, 1'b1, 4'd4, 64'h2); tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 64'h0);
        chk_mwr("merge4", 4'd4, 64'h2);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 64'h0);
        chk("merge_nowr", 64'(t1_writeA), 64'h0);
        tick();

        // Write to the head address replaces the head drain
        drive(1'b1, 4'd0, 1'b1, 4'd1, 64'h55); tick();
        drive(1'b1, 4'd0, 1'b1, 4'd2, 64'h66); tick();
        drive(1'b0, 4'd0, 1'b1, 4'd1, 64'h77);
        chk_mwr("head1", 4'd1, 64'h77);
        tick();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 64'h0);
        chk_mwr("drain2", 4'd2, 64'h66);
        tick();

        // Direct write with empty buffer
        drive(1'b0, 4'd0, 1'b1, 4'd6, 64'h88);
        chk_mwr("direct6", 4'd6, 64'h88);
        tick();

        // Reset with a read in flight and the buffer occupied
        drive(1'b1, 4'd0, 1'b1, 4'd5, 64'h42); tick();
        drive(1'b1, 4'd6, 1'b1, 4'd7, 64'h43);
        #2;
        rst = 1'b1;
        read = 1'b0; write = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_rvld", 64'(rd_vld), 64'h0);
        chk("mrst_cnt", 64'(wr_cnt), 64'h0);
        chk("mrst_ready", 64'(ready), 64'h0);
        chk("mrst_wra", 64'(t1_writeA), 64'h0);
        rst = 1'b0;
        model_reset();
        run_init();
        drive(1'b1, 4'd5, 1'b0, 4'd0, 64'h0); tick();
        drive(1'b1, 4'd6, 1'b0, 4'd0, 64'h0); tick();

        // Randomised traffic over a narrow address range to provoke hits
        for (int n = 0; n < 400; n++) begin
            r_r  = ($urandom_range(0, 9) < 4);
            r_w  = 1'($urandom_range(0, 1));
            r_ra = 4'($urandom_range(0, 7));
            r_wa = 4'($urandom_range(0, 7));
            r_wd = {$urandom, $urandom};
            drive(r_r, r_ra, r_w, r_wa, r_wd);
            tick();
        end
        idle(6);
        for (int a = 0; a < 16; a++) chk("final_mem", mem[a], lm[a]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/algo_1r1w1p_wrbuf_top.md
ALGO_1R1W1P_WRBUF_TOP -- requirements
Module: algo_1r1w1p_wrbuf_top

Interface
REQ-001 WIDTH, 64, data word width in bits.
REQ-002 NUMADDR, 8192, logical depth; BITADDR, 13, address width.
REQ-003 NUMWBUF, 4, write-buffer entries (2..16); BITWBUF, 2, log2(NUMWBUF).
REQ-004 SRAM_DELAY, 1, cycles from t1_readA to t1_doutA valid; FLOPOUT, 0, extra output register stage (0/1).
REQ-005 clk  in  1  single clock, all logic rising-edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 write, wr_adr, din  in  1/BITADDR/WIDTH  write request, address, data.
REQ-008 read, rd_adr  in  1/BITADDR  read request and address.
REQ-009 ready  out  1  high when init is complete and requests are accepted.
REQ-010 rd_vld, rd_dout  out  1/WIDTH  read return strobe and data.
REQ-011 wr_full  out  1  buffer holds NUMWBUF entries; wr_cnt  out  BITWBUF+1  occupancy.
REQ-012 ovf_err  out  1  sticky: write dropped because of overflow.
REQ-013 t1_readA, t1_writeA  out  1  single-port macro read/write strobes, mutually exclusive.
REQ-014 t1_addrA  out  BITADDR; t1_dinA, t1_bwA  out  WIDTH; t1_doutA  in  WIDTH.

Function
REQ-015 FSM states: INIT, RUN; rst forces INIT with init counter 0.
REQ-016 INIT: one zero-data, all-ones-bw write per cycle to address = counter, 0..NUMADDR-1; go to RUN the cycle after address NUMADDR-1; ready=1 in RUN only.
REQ-017 In INIT, read/write are ignored; no rd_vld, no buffer change.
REQ-018 Macro port is driven combinationally in the request cycle; priority: read > buffer drain / direct write.
REQ-019 Read at cycle t: t1_readA at t; rd_vld=1 at t+SRAM_DELAY+FLOPOUT, fixed latency, no back-pressure.
REQ-020 Read hit in buffer (address match, unique entry): rd_dout = buffered data captured at t, returned at same latency; t1_readA is still issued.
REQ-021 Read and write same cycle, same address: read returns prior contents (buffer or SRAM), not din.
REQ-022 Read+write same cycle: write enters buffer; if address already buffered, overwrite that entry in place (wr_cnt unchanged).
REQ-023 Write, no read, buffer empty: direct macro write, buffer untouched.
REQ-024 Write, no read, buffer non-empty: drain oldest entry to macro and enqueue/merge write the same cycle; if write address equals head, macro writes din and head is removed without enqueue.
REQ-025 No write, no read, buffer non-empty: drain oldest entry; wr_cnt decrements.
REQ-026 Buffer is FIFO-ordered for drain, addresses kept unique; wr_cnt saturates at NUMWBUF.
REQ-027 Write requiring enqueue while wr_full=1 and read=1: write dropped, ovf_err set until rst; merge hits while full are accepted.
REQ-028 Pointer arithmetic wraps modulo NUMWBUF; wr_full = (wr_cnt==NUMWBUF).
REQ-029 Buffer drains only in cycles without a read; pending entries remain visible to forwarding.

Reset
REQ-030 On rst: ready=0, rd_vld=0, rd_dout=0, wr_cnt=0, wr_full=0, ovf_err=0, t1_readA=0, t1_writeA=0, FSM=INIT.
REQ-031 rst mid-operation discards buffer contents and in-flight reads (no rd_vld after rst), then reruns INIT.

Verification
REQ-032 Reset release, NUMADDR=16 -> 16 zero writes to 0..15, ready=1 at cycle 17, then read 5 -> rd_dout=0.
REQ-033 Write 3<=0xA5 with read 7 same cycle, then idle -> wr_cnt=1, next cycle drain writes 0xA5 to 3, wr_cnt=0.
REQ-034 Buffered 3=0xA5 and read 3 issued while buffer non-empty -> rd_dout=0xA5 after SRAM_DELAY+FLOPOUT cycles.
REQ-035 Read 9 + write 9<=0x11 same cycle, then read 9 -> first return old value 0, second 0x11.
REQ-036 NUMWBUF=4, 5 cycles of read+write to distinct addresses -> wr_full after 4th, 5th write dropped, ovf_err=1 stays set.
REQ-037 Two read+write to address 4 (0x1, 0x2) -> wr_cnt=1, drain writes 0x2 only.
